btn_charge: RTL and testbench
=============================

# btn_charge

Button front-end feeding `wechat_jump_fsm`. Synchronises and debounces the raw player button, then measures hold time as a 0–14 squeeze level. On release it emits a one-cycle pulse with a latched launch velocity for `jump`. The squeeze level also drives the man-compression graphic and the `Buzzer` scale.

## Interface
- `DEBOUNCE_CYC`, 250000: consecutive stable cycles needed to accept a level change (~10 ms at 25.175 MHz).
- `CHARGE_TICK_CYC`, 1678333: cycles per squeeze increment (~66.7 ms).
- `SQUEEZE_MAX`, 14: squeeze saturation value.
- `V_BASE`, 1: velocity at squeeze 0.
- `V_STEP`, 9: velocity per squeeze step. Defaults give a maximum of 127.
- `clk_machine  in  1`: single clock, 25.175 MHz.
- `rst_n  in  1`: asynchronous, active-low reset.
- `i_btn  in  1`: raw button, active-high, asynchronous to the clock.
- `i_enable  in  1`: FSM permits charging (waiting-for-input state).
- `o_btn_level  out  1`: debounced button level.
- `o_press_pulse  out  1`: one cycle on an accepted rising edge.
- `o_charging  out  1`: charge in progress.
- `o_squeeze  out  4`: current squeeze level, 0..SQUEEZE_MAX.
- `o_release_pulse  out  1`: one cycle marking a valid jump request.
- `o_v_init  out  11`: launch velocity, latched at release.

## Operation
- Reset values: all outputs 0; state IDLE; sync flops, debounce counter and tick counter all 0.
- **Sync:** two-flop synchroniser on `i_btn`, giving `s2`.
- **Debounce:**
  - The counter increments while `s2 != o_btn_level` and clears whenever they are equal.
  - When the counter reaches `DEBOUNCE_CYC-1` with the mismatch still present, `o_btn_level` toggles on the next edge and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYC` cycles never changes `o_btn_level`.
- **Edge pulses:** `o_press_pulse` marks an accepted rising edge (independent of `i_enable`). A falling edge is detected internally as `db_fall`.
- **State IDLE:**
  - `db_rise` with `i_enable=1` → CHARGE. In the same edge: `o_charging`←1, squeeze←0, tick←0.
  - `db_rise` with `i_enable=0` → LOCK.
- **State CHARGE:**
  - The tick counter increments every cycle.
  - At `CHARGE_TICK_CYC-1` the tick counter wraps to 0 and squeeze increments, saturating at `SQUEEZE_MAX`. At saturation the tick counter keeps wrapping.
  - `db_fall` → IDLE with:
    - `o_release_pulse`←1 for one cycle;
    - `o_v_init`←`V_BASE + squeeze*V_STEP`, using the squeeze value before any same-cycle increment;
    - `o_charging`←0 and squeeze←0.
  - `i_enable` low → IDLE if the button is already released, otherwise LOCK. Either way: squeeze←0, `o_charging`←0, no release pulse, `o_v_init` unchanged.
  - `i_enable` low has priority over `db_fall` when both occur in the same cycle (abort, no pulse).
- **State LOCK:** ignores everything until `db_fall`, then → IDLE. A press held across an enable rise never starts a charge; a fresh press is required.
- **Velocity arithmetic:** unsigned, computed at 11 bits. The elaboration-time check `V_BASE + SQUEEZE_MAX*V_STEP < 2048` must hold.
- **`o_v_init` hold:** holds its value until the next release. It is not cleared by a new press.
- **Reset mid-charge:** immediate return to reset values. No release pulse.

## Timing
- A clean raw edge produces an `o_btn_level` change exactly `DEBOUNCE_CYC+2` clocks later. `o_press_pulse` is registered and high in the cycle after the level change.
- **Squeeze:** k (k ≤ `SQUEEZE_MAX`) is first visible k·`CHARGE_TICK_CYC` cycles after `o_charging` rises.
- **Release:** `o_release_pulse` and the new `o_v_init` appear in the same cycle, one clock after `o_btn_level` falls. `o_squeeze` reads 0 from that same cycle.
- **Throughput:** no back-pressure. The FSM must sample `o_v_init` on `o_release_pulse`.

## Structure
- **Package `btn_charge_pkg`:**
  - state enum (IDLE, CHARGE, LOCK);
  - `SQUEEZE_W=4` and `V_W=11`;
  - a function `v_of_squeeze(sq)`.
- **Sub-module `btn_debounce`:** sync, counter, level and rise/fall pulses, parameterised by `DEBOUNCE_CYC`. The top level holds the charge FSM, tick counter and velocity latch.

## Test plan
Bench parameters: `DEBOUNCE_CYC=4`, `CHARGE_TICK_CYC=10`, other parameters at defaults.

1. **Glitch rejection:** 3-cycle high glitch on `i_btn` → `o_btn_level` stays 0, no pulses.
2. **Clean press, then release after 35 cycles of charging:**
   - press: `o_btn_level`=1 six cycles after the raw edge, `o_press_pulse` the next cycle;
   - `o_squeeze` steps 1, 2, 3 at 10, 20, 30 cycles;
   - release: `o_release_pulse` fires once with `o_v_init`=28 (1+3·9), and squeeze returns to 0.
3. **Saturation:** hold for 200 charge cycles → squeeze holds at 14; release gives `o_v_init`=127.
4. **Press while `i_enable`=0, then `i_enable`←1 while still held:** no charging, no release pulse. A subsequent fresh press charges normally.
5. **Abort:** drop `i_enable` at squeeze 5 while held → squeeze 0, state LOCK, no pulse, `o_v_init` keeps its previous value (28).
6. **Reset mid-charge:** assert `rst_n`=0 at squeeze 7 → all outputs 0 immediately, no pulse after deassertion, even if the button is then released.

Source files
------------

// File: rtl/btn_charge_pkg.sv
// Shared types, widths and the squeeze-to-velocity mapping for the button charge front-end.
package btn_charge_pkg;

    localparam int unsigned SQUEEZE_W = 4;
    localparam int unsigned V_W       = 11;

    typedef enum logic [1:0] {
        StIdle,
        StCharge,
        StLock
    } state_e;

    function automatic logic [V_W-1:0] v_of_squeeze(input logic [SQUEEZE_W-1:0] sq,
                                                    input int unsigned base,
                                                    input int unsigned step);
        int unsigned v;
        v = base + 32'(sq) * step;
        return v[V_W-1:0];
    endfunction

endpackage

// File: rtl/btn_charge_if.sv
// Button front-end signal bundle: player/FSM inputs and debounced level, charge and launch outputs.
interface btn_charge_if;
    import btn_charge_pkg::*;

    logic                 i_btn;
    logic                 i_enable;
    logic                 o_btn_level;
    logic                 o_press_pulse;
    logic                 o_charging;
    logic [SQUEEZE_W-1:0] o_squeeze;
    logic                 o_release_pulse;
    logic [V_W-1:0]       o_v_init;

    modport slave (
        input  i_btn, i_enable,
        output o_btn_level, o_press_pulse, o_charging, o_squeeze, o_release_pulse, o_v_init
    );

    modport master (
        output i_btn, i_enable,
        input  o_btn_level, o_press_pulse, o_charging, o_squeeze, o_release_pulse, o_v_init
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; level changes only after DEBOUNCE_CYC
// consecutive mismatching samples.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 250000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned   CntW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    logic            s1_q, s2_q;
    logic            level_q, level_d;
    logic            prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
        end
    end

    // Edge strobes are valid for the one cycle right after the level flips.
    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/btn_charge.sv
// Debounced button charge meter: measures hold time as a squeeze level and emits a
// one-cycle release pulse with the latched launch velocity.
module btn_charge
    import btn_charge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC    = 250000,
    parameter int unsigned CHARGE_TICK_CYC = 1678333,
    parameter int unsigned SQUEEZE_MAX     = 14,
    parameter int unsigned V_BASE          = 1,
    parameter int unsigned V_STEP          = 9
) (
    input logic         clk_machine,
    input logic         rst_n,
    btn_charge_if.slave btn_bus
);

    localparam int unsigned    TickW    = (CHARGE_TICK_CYC > 1) ? $clog2(CHARGE_TICK_CYC) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(CHARGE_TICK_CYC - 1);
    localparam logic [SQUEEZE_W-1:0] SqMax = SQUEEZE_W'(SQUEEZE_MAX);

    if (V_BASE + SQUEEZE_MAX * V_STEP >= 2048) begin : g_v_range_check
        $error("btn_charge: V_BASE + SQUEEZE_MAX*V_STEP must fit in 11 bits");
    end

    logic db_level, db_rise, db_fall;

    btn_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk_i  (clk_machine),
        .rst_ni (rst_n),
        .btn_i  (btn_bus.i_btn),
        .level_o(db_level),
        .rise_o (db_rise),
        .fall_o (db_fall)
    );

    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [SQUEEZE_W-1:0] squeeze_q, squeeze_d;
    logic                 charging_q, charging_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic [V_W-1:0]       v_init_q, v_init_d;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        squeeze_d  = squeeze_q;
        charging_d = charging_q;
        press_d    = db_rise;
        release_d  = 1'b0;
        v_init_d   = v_init_q;
        unique case (state_q)
            StIdle: begin
                if (db_rise) begin
                    if (btn_bus.i_enable) begin
                        state_d    = StCharge;
                        charging_d = 1'b1;
                        squeeze_d  = '0;
                        tick_d     = '0;
                    end else begin
                        state_d = StLock;
                    end
                end
            end
            StCharge: begin
                // Losing enable wins over a same-cycle release: abort without a jump.
                if (!btn_bus.i_enable) begin
                    state_d    = db_level ? StLock : StIdle;
                    charging_d = 1'b0;
                    squeeze_d  = '0;
                    tick_d     = '0;
                end else if (db_fall) begin
                    state_d    = StIdle;
                    release_d  = 1'b1;
                    v_init_d   = v_of_squeeze(squeeze_q, V_BASE, V_STEP);
                    charging_d = 1'b0;
                    squeeze_d  = '0;
                    tick_d     = '0;
                end else if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (squeeze_q < SqMax) begin
                        squeeze_d = squeeze_q + SQUEEZE_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StLock: begin
                if (db_fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_machine or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            squeeze_q  <= '0;
            charging_q <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            v_init_q   <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            squeeze_q  <= squeeze_d;
            charging_q <= charging_d;
            press_q    <= press_d;
            release_q  <= release_d;
            v_init_q   <= v_init_d;
        end
    end

    assign btn_bus.o_btn_level     = db_level;
    assign btn_bus.o_press_pulse   = press_q;
    assign btn_bus.o_charging      = charging_q;
    assign btn_bus.o_squeeze       = squeeze_q;
    assign btn_bus.o_release_pulse = release_q;
    assign btn_bus.o_v_init        = v_init_q;

endmodule

// File: tb/tb_btn_charge.sv
// Scripted scenarios plus random button/enable traffic, checked every cycle against an
// event-level model (accept after D stable samples, squeeze from elapsed charge time).
module tb_btn_charge;
    import btn_charge_pkg::*;

    localparam int D    = 4;
    localparam int T    = 10;
    localparam int SMAX = 14;
    localparam int VB   = 1;
    localparam int VS   = 9;

    logic clk_machine = 1'b0;
    logic rst_n       = 1'b0;

    btn_charge_if bus ();

    btn_charge #(
        .DEBOUNCE_CYC   (D),
        .CHARGE_TICK_CYC(T)
    ) dut (
        .clk_machine(clk_machine),
        .rst_n      (rst_n),
        .btn_bus    (bus)
    );

    always #5 clk_machine = ~clk_machine;

    int errors = 0;
    int checks = 0;
    int rel_seen = 0;
    int press_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: mode 0 idle, 1 charging, 2 locked.
    int m_s1, m_s2, m_lvl, m_run, m_rose, m_fell;
    int m_press, m_rel, m_v, m_mode, m_start, m_n;

    function automatic int sq_at(input int n);
        int s;
        if (m_mode != 1) return 0;
        s = (n - m_start) / T;
        return (s > SMAX) ? SMAX : s;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_rose = 0; m_fell = 0;
        m_press = 0; m_rel = 0; m_v = 0; m_mode = 0; m_start = 0; m_n = 0;
    endtask

    task automatic model_step(input int raw, input int en);
        int pre_lvl, rose, fell, pre_sq, new_rose, new_fell;
        m_n++;
        pre_lvl  = m_lvl;
        rose     = m_rose;
        fell     = m_fell;
        pre_sq   = sq_at(m_n - 1);
        new_rose = 0;
        new_fell = 0;
        if (m_s2 != m_lvl) begin
            m_run++;
            if (m_run == D) begin
                m_lvl    = 1 - m_lvl;
                m_run    = 0;
                new_rose = m_lvl;
                new_fell = 1 - m_lvl;
            end
        end else begin
            m_run = 0;
        end
        m_s2    = m_s1;
        m_s1    = raw;
        m_press = rose;
        m_rel   = 0;
        case (m_mode)
            0: if (rose != 0) begin
                if (en != 0) begin
                    m_mode  = 1;
                    m_start = m_n;
                end else begin
                    m_mode = 2;
                end
            end
            1: if (en == 0) begin
                m_mode = (pre_lvl != 0) ? 2 : 0;
            end else if (fell != 0) begin
                m_rel  = 1;
                m_v    = VB + pre_sq * VS;
                m_mode = 0;
            end
            default: if (fell != 0) m_mode = 0;
        endcase
        m_rose = new_rose;
        m_fell = new_fell;
    endtask

    initial model_reset();

    always @(posedge clk_machine) begin : compare_p
        int raw, en, rst;
        raw = int'(bus.i_btn);
        en  = int'(bus.i_enable);
        rst = int'(rst_n);
        #1;
        if (rst == 0) model_reset();
        else model_step(raw, en);
        chk("btn_level", int'(bus.o_btn_level), m_lvl);
        chk("press_pulse", int'(bus.o_press_pulse), m_press);
        chk("charging", int'(bus.o_charging), (m_mode == 1) ? 1 : 0);
        chk("squeeze", int'(bus.o_squeeze), sq_at(m_n));
        chk("release_pulse", int'(bus.o_release_pulse), m_rel);
        chk("v_init", int'(bus.o_v_init), m_v);
        if (bus.o_release_pulse) rel_seen++;
        if (bus.o_press_pulse) press_seen++;
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk_machine);
    endtask

    function automatic int sig_val(input int sel);
        case (sel)
            0:       return int'(bus.o_btn_level);
            1:       return int'(bus.o_charging);
            2:       return int'(bus.o_release_pulse);
            default: return int'(bus.o_squeeze);
        endcase
    endfunction

    task automatic wait_sig(input string name, input int sel, input int val, input int budget,
                            output int n);
        n = 0;
        while (sig_val(sel) != val && n < budget) begin
            @(negedge clk_machine);
            n++;
        end
        checks++;
        if (sig_val(sel) != val) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, got %0d, expected %0d",
                     name, n, sig_val(sel), val);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.i_btn    = 1'b0;
        bus.i_enable = 1'b0;
        cyc(3);
        chk("reset_level", int'(bus.o_btn_level), 0);
        chk("reset_charging", int'(bus.o_charging), 0);
        chk("reset_v_init", int'(bus.o_v_init), 0);
        rst_n = 1'b1;
        cyc(2);

        // Glitch shorter than the debounce window.
        bus.i_enable = 1'b1;
        bus.i_btn    = 1'b1;
        cyc(3);
        bus.i_btn = 1'b0;
        cyc(12);
        chk("glitch_level", int'(bus.o_btn_level), 0);
        chk("glitch_press_count", press_seen, 0);

        // Clean press, charge to squeeze 3, release.
        bus.i_btn = 1'b1;
        wait_sig("press_level", 0, 1, 30, n);
        chk("press_latency", n, 6);
        cyc(1);
        chk("press_pulse_next", int'(bus.o_press_pulse), 1);
        chk("charge_start", int'(bus.o_charging), 1);
        cyc(10);
        chk("squeeze_at_10", int'(bus.o_squeeze), 1);
        cyc(10);
        chk("squeeze_at_20", int'(bus.o_squeeze), 2);
        cyc(10);
        chk("squeeze_at_30", int'(bus.o_squeeze), 3);
        bus.i_btn = 1'b0;
        wait_sig("release_28", 2, 1, 30, n);
        chk("v_init_28", int'(bus.o_v_init), 28);
        chk("release_squeeze_0", int'(bus.o_squeeze), 0);
        cyc(1);
        chk("release_one_cycle", int'(bus.o_release_pulse), 0);
        chk("release_count_1", rel_seen, 1);
        cyc(5);

        // Press while disabled, then enable while held: no charge.
        bus.i_enable = 1'b0;
        bus.i_btn    = 1'b1;
        cyc(10);
        bus.i_enable = 1'b1;
        cyc(20);
        chk("locked_no_charge", int'(bus.o_charging), 0);
        bus.i_btn = 1'b0;
        cyc(12);
        chk("locked_no_release", rel_seen, 1);
        bus.i_btn = 1'b1;
        wait_sig("fresh_press_charges", 1, 1, 20, n);

        // Abort at squeeze 5 by dropping enable while held.
        wait_sig("squeeze_5", 3, 5, 80, n);
        bus.i_enable = 1'b0;
        cyc(1);
        chk("abort_charging", int'(bus.o_charging), 0);
        chk("abort_squeeze", int'(bus.o_squeeze), 0);
        chk("abort_v_hold", int'(bus.o_v_init), 28);
        cyc(1);
        bus.i_enable = 1'b1;
        cyc(15);
        chk("abort_locked", int'(bus.o_charging), 0);
        bus.i_btn = 1'b0;
        cyc(12);
        chk("abort_no_release", rel_seen, 1);

        // Saturation.
        bus.i_btn = 1'b1;
        wait_sig("sat_charge", 1, 1, 20, n);
        cyc(200);
        chk("sat_squeeze", int'(bus.o_squeeze), 14);
        bus.i_btn = 1'b0;
        wait_sig("release_127", 2, 1, 30, n);
        chk("v_init_127", int'(bus.o_v_init), 127);
        chk("release_count_2", rel_seen, 2);
        cyc(5);

        // Reset in the middle of a charge.
        bus.i_btn = 1'b1;
        wait_sig("squeeze_7", 3, 7, 120, n);
        rst_n = 1'b0;
        #1;
        chk("rst_level", int'(bus.o_btn_level), 0);
        chk("rst_charging", int'(bus.o_charging), 0);
        chk("rst_squeeze", int'(bus.o_squeeze), 0);
        chk("rst_v_init", int'(bus.o_v_init), 0);
        cyc(2);
        bus.i_btn = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(15);
        chk("rst_no_release", rel_seen, 2);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            bus.i_btn    = 1'($urandom_range(1, 0));
            bus.i_enable = ($urandom_range(7, 0) != 0);
            if ($urandom_range(5, 0) == 0) cyc(int'($urandom_range(180, 60)));
            else cyc(int'($urandom_range(30, 1)));
        end
        bus.i_btn = 1'b0;
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
